// File: rtl/filter_peak_detector.sv
// Peak detector for the trapezoidal shaper output stream.
// Qualifies each pulse against a threshold with hysteresis, tracks the pulse
// maximum, its timestamp, the pulse width and pile-up, and presents one event
// per pulse through a single-entry valid/ready output buffer.
module filter_peak_detector #(
    parameter int DATA_W    = 16,
    parameter int TS_W      = 32,
    parameter int WIDTH_W   = 8,
    parameter int THRESHOLD = 100,
    parameter int HYST      = 16,
    parameter int MIN_WIDTH = 2
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic signed [DATA_W-1:0] in_data,
    input  logic                     in_valid,
    output logic                     peak_valid,
    input  logic                     peak_ready,
    output logic signed [DATA_W-1:0] peak_amp,
    output logic [TS_W-1:0]          peak_time,
    output logic [WIDTH_W-1:0]       peak_width,
    output logic                     peak_pileup,
    output logic [15:0]              drop_count
);

    // One extra bit keeps threshold, dip and rise arithmetic free of overflow.
    localparam int XW = DATA_W + 1;
    localparam logic signed [XW-1:0] THR_HI = XW'(THRESHOLD);
    localparam logic signed [XW-1:0] THR_LO = XW'(THRESHOLD - HYST);
    localparam logic signed [XW-1:0] HYST_X = XW'(HYST);
    localparam logic [WIDTH_W-1:0]   MIN_W  = WIDTH_W'(MIN_WIDTH);
    localparam logic [WIDTH_W-1:0]   W_MAX  = {WIDTH_W{1'b1}};

    typedef enum logic [0:0] {
        StIdle,
        StPulse
    } state_e;

    state_e                    state_q;
    logic [TS_W-1:0]           ts_q;
    logic signed [DATA_W-1:0]  max_q;
    logic [TS_W-1:0]           max_ts_q;
    logic [WIDTH_W-1:0]        width_q;
    logic                      dropped_q;
    logic signed [DATA_W-1:0]  valley_q;
    logic                      pileup_q;

    logic signed [XW-1:0] s_ext;
    logic signed [XW-1:0] max_ext;
    logic signed [XW-1:0] valley_ext;
    logic                 above_thr;
    logic                 below_lo;
    logic                 new_max;
    logic                 is_dip;
    logic                 is_rise;
    logic                 pulse_end;
    logic                 emit;
    logic                 transfer;
    logic signed [DATA_W-1:0] valley_next;

    assign s_ext      = {in_data[DATA_W-1], in_data};
    assign max_ext    = {max_q[DATA_W-1], max_q};
    assign valley_ext = {valley_q[DATA_W-1], valley_q};

    // Per-sample decisions against the current pulse state.
    always_comb begin
        above_thr   = s_ext > THR_HI;
        below_lo    = s_ext <= THR_LO;
        new_max     = s_ext > max_ext;
        is_dip      = s_ext <= (max_ext - HYST_X);
        is_rise     = dropped_q && (s_ext >= (valley_ext + HYST_X));
        pulse_end   = in_valid && (state_q == StPulse) && below_lo;
        emit        = pulse_end && (width_q >= MIN_W);
        transfer    = peak_valid && peak_ready;
        valley_next = valley_q;
        if (!dropped_q || (in_data < valley_q)) begin
            valley_next = in_data;
        end
    end

    // Timestamp and pulse-tracking FSM; everything holds while in_valid is low.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= StIdle;
            ts_q      <= '0;
            max_q     <= '0;
            max_ts_q  <= '0;
            width_q   <= '0;
            dropped_q <= 1'b0;
            valley_q  <= '0;
            pileup_q  <= 1'b0;
        end else if (in_valid) begin
            ts_q <= ts_q + 1'b1;
            unique case (state_q)
                StIdle: begin
                    if (above_thr) begin
                        state_q   <= StPulse;
                        max_q     <= in_data;
                        max_ts_q  <= ts_q;
                        width_q   <= WIDTH_W'(1);
                        dropped_q <= 1'b0;
                        pileup_q  <= 1'b0;
                    end
                end
                StPulse: begin
                    if (below_lo) begin
                        // Terminating sample is not part of the pulse.
                        state_q <= StIdle;
                    end else begin
                        if (width_q != W_MAX) begin
                            width_q <= width_q + 1'b1;
                        end
                        // Strict compare: ties keep the earlier maximum.
                        if (new_max) begin
                            max_q    <= in_data;
                            max_ts_q <= ts_q;
                        end
                        if (is_dip) begin
                            dropped_q <= 1'b1;
                            valley_q  <= valley_next;
                        end
                        if (is_rise) begin
                            pileup_q <= 1'b1;
                        end
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end

    // Single-entry event buffer with valid/ready handshake and drop counting.
    always_ff @(posedge clk) begin
        if (reset) begin
            peak_valid  <= 1'b0;
            peak_amp    <= '0;
            peak_time   <= '0;
            peak_width  <= '0;
            peak_pileup <= 1'b0;
            drop_count  <= '0;
        end else if (emit && (!peak_valid || transfer)) begin
            peak_valid  <= 1'b1;
            peak_amp    <= max_q;
            peak_time   <= max_ts_q;
            peak_width  <= width_q;
            peak_pileup <= pileup_q;
        end else begin
            if (emit && drop_count != 16'hFFFF) begin
                drop_count <= drop_count + 16'd1;
            end
            if (transfer) begin
                peak_valid <= 1'b0;
            end
        end
    end

endmodule
